// File: rtl/captura_jugada_if.sv
// Bundles the button levels and the move/board outputs of the move-capture stage.
// jugada_valida is a one-cycle strobe with no backpressure: the consumer samples jugada whenever it is high.
interface captura_jugada_if;
  logic       btn_izq;
  logic       btn_der;
  logic       btn_ok;
  logic       nuevo_juego;
  logic [5:0] jugada;
  logic       jugada_valida;
  logic       ocupada;
  logic [3:0] cursor;
  logic       turno;
  logic [8:0] tablero_x;
  logic [8:0] tablero_o;
  logic       lleno;
  logic [1:0] estado;

  modport master (
    input  btn_izq, btn_der, btn_ok, nuevo_juego,
    output jugada, jugada_valida, ocupada, cursor, turno,
           tablero_x, tablero_o, lleno, estado
  );

  modport slave (
    output btn_izq, btn_der, btn_ok, nuevo_juego,
    input  jugada, jugada_valida, ocupada, cursor, turno,
           tablero_x, tablero_o, lleno, estado
  );
endinterface

// File: rtl/captura_jugada.sv
// Move-capture stage for tic-tac-toe: turns button levels into cursor moves and 6-bit move words.
// Tracks turn and board occupancy; halts in FIN once all nine cells are taken.
module captura_jugada #(
  parameter logic [1:0] CODIGO_X      = 2'b01,
  parameter logic [1:0] CODIGO_O      = 2'b10,
  parameter logic [3:0] CELDA_INICIAL = 4'd4
) (
  input  logic              clk,
  input  logic              reset,
  captura_jugada_if.master  bus
);

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    EMITE  = 2'd1,
    FIN    = 2'd2
  } estado_t;

  estado_t    r_estado;
  logic       r_prev_izq;
  logic       r_prev_der;
  logic       r_prev_ok;
  logic [3:0] r_cursor;
  logic       r_turno;
  logic [8:0] r_tab_x;
  logic [8:0] r_tab_o;
  logic [5:0] r_jugada;
  logic       r_valida;
  logic       r_ocupada;
  logic       r_lleno;

  logic       w_rise_izq;
  logic       w_rise_der;
  logic       w_rise_ok;
  logic       w_celda_ocupada;
  logic [8:0] w_mascara;
  logic [3:0] w_cursor_mas;
  logic [3:0] w_cursor_menos;
  logic       w_tablero_lleno;

  assign w_rise_izq      = bus.btn_izq & ~r_prev_izq;
  assign w_rise_der      = bus.btn_der & ~r_prev_der;
  assign w_rise_ok       = bus.btn_ok  & ~r_prev_ok;
  assign w_celda_ocupada = r_tab_x[r_cursor] | r_tab_o[r_cursor];
  assign w_mascara       = 9'd1 << r_cursor;
  assign w_cursor_mas    = (r_cursor == 4'd8) ? 4'd0 : r_cursor + 4'd1;
  assign w_cursor_menos  = (r_cursor == 4'd0) ? 4'd8 : r_cursor - 4'd1;
  // The board bit for the move being emitted is already set while in EMITE.
  assign w_tablero_lleno = &(r_tab_x | r_tab_o);

  always_ff @(posedge clk) begin
    if (reset || bus.nuevo_juego) begin
      r_estado   <= ESPERA;
      r_prev_izq <= 1'b0;
      r_prev_der <= 1'b0;
      r_prev_ok  <= 1'b0;
      r_cursor   <= CELDA_INICIAL;
      r_turno    <= 1'b0;
      r_tab_x    <= 9'd0;
      r_tab_o    <= 9'd0;
      r_jugada   <= 6'd0;
      r_valida   <= 1'b0;
      r_ocupada  <= 1'b0;
      r_lleno    <= 1'b0;
    end else begin
      // Edge history keeps tracking in every state so a button held through EMITE/FIN does not fire later.
      r_prev_izq <= bus.btn_izq;
      r_prev_der <= bus.btn_der;
      r_prev_ok  <= bus.btn_ok;
      r_valida   <= 1'b0;
      r_ocupada  <= 1'b0;
      case (r_estado)
        ESPERA: begin
          if (w_rise_ok) begin
            if (w_celda_ocupada) begin
              r_ocupada <= 1'b1;
            end else begin
              r_jugada <= {(r_turno ? CODIGO_O : CODIGO_X), r_cursor};
              if (r_turno) r_tab_o <= r_tab_o | w_mascara;
              else         r_tab_x <= r_tab_x | w_mascara;
              r_valida <= 1'b1;
              r_estado <= EMITE;
            end
          end else if (w_rise_der && !w_rise_izq) begin
            r_cursor <= w_cursor_mas;
          end else if (w_rise_izq && !w_rise_der) begin
            r_cursor <= w_cursor_menos;
          end
        end
        EMITE: begin
          r_turno <= ~r_turno;
          if (w_tablero_lleno) begin
            r_estado <= FIN;
            r_lleno  <= 1'b1;
          end else begin
            r_estado <= ESPERA;
          end
        end
        FIN: begin
          r_estado <= FIN;
        end
        default: r_estado <= ESPERA;
      endcase
    end
  end

  assign bus.jugada        = r_jugada;
  assign bus.jugada_valida = r_valida;
  assign bus.ocupada       = r_ocupada;
  assign bus.cursor        = r_cursor;
  assign bus.turno         = r_turno;
  assign bus.tablero_x     = r_tab_x;
  assign bus.tablero_o     = r_tab_o;
  assign bus.lleno         = r_lleno;
  assign bus.estado        = r_estado;

endmodule

// File: tb/tb_captura_jugada.sv
// Directed bench for captura_jugada: strobe events are checked against an expected queue by a monitor,
// board/cursor/turn state is checked directly at chosen points.
module tb_captura_jugada;
  logic clk;
  logic reset;
  captura_jugada_if bus ();

  captura_jugada dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected strobe events: {is_ocupada, jugada}
  logic [6:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  logic [3:0] m_cursor;
  logic       m_turno;
  logic [8:0] m_x;
  logic [8:0] m_o;
  logic [5:0] m_jugada;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.jugada_valida || bus.ocupada) begin
        if (bus.jugada_valida && bus.ocupada) begin
          checks++;
          errors++;
          $display("FAIL strobe_both: valida and ocupada high together at %0t", $time);
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL strobe_unexpected: ocupada=%0b jugada=0x%0h with empty queue at %0t",
                   bus.ocupada, bus.jugada, $time);
        end else begin
          check("strobe_event", {9'd0, bus.ocupada, bus.jugada}, {9'd0, exp_q.pop_front()});
        end
      end
      check("invariant_disjoint", {7'd0, bus.tablero_x & bus.tablero_o}, 16'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press_der();
    bus.btn_der = 1'b1; tick();
    bus.btn_der = 1'b0; tick();
  endtask

  task automatic press_izq();
    bus.btn_izq = 1'b1; tick();
    bus.btn_izq = 1'b0; tick();
  endtask

  task automatic model_der();
    m_cursor = (m_cursor == 4'd8) ? 4'd0 : m_cursor + 4'd1;
  endtask

  task automatic model_izq();
    m_cursor = (m_cursor == 4'd0) ? 4'd8 : m_cursor - 4'd1;
  endtask

  task automatic goto(input logic [3:0] target);
    for (int k = 0; k < 9 && m_cursor != target; k++) begin
      press_der();
      model_der();
    end
    check("goto_cursor", {12'd0, bus.cursor}, {12'd0, target});
  endtask

  // Accepted move on the current model cursor.
  task automatic place();
    m_jugada = {(m_turno ? 2'b10 : 2'b01), m_cursor};
    exp_q.push_back({1'b0, m_jugada});
    if (m_turno) m_o[m_cursor] = 1'b1;
    else         m_x[m_cursor] = 1'b1;
    bus.btn_ok = 1'b1; tick();
    bus.btn_ok = 1'b0; tick();
    m_turno = ~m_turno;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_cursor"}, {12'd0, bus.cursor}, {12'd0, m_cursor});
    check({tag, "_turno"},  {15'd0, bus.turno},  {15'd0, m_turno});
    check({tag, "_tab_x"},  {7'd0, bus.tablero_x}, {7'd0, m_x});
    check({tag, "_tab_o"},  {7'd0, bus.tablero_o}, {7'd0, m_o});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_jugada"},  {10'd0, bus.jugada}, 16'd0);
    check({tag, "_valida"},  {15'd0, bus.jugada_valida}, 16'd0);
    check({tag, "_ocupada"}, {15'd0, bus.ocupada}, 16'd0);
    check({tag, "_cursor"},  {12'd0, bus.cursor}, 16'd4);
    check({tag, "_turno"},   {15'd0, bus.turno}, 16'd0);
    check({tag, "_tab_x"},   {7'd0, bus.tablero_x}, 16'd0);
    check({tag, "_tab_o"},   {7'd0, bus.tablero_o}, 16'd0);
    check({tag, "_lleno"},   {15'd0, bus.lleno}, 16'd0);
    check({tag, "_estado"},  {14'd0, bus.estado}, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset           = 1'b1;
    bus.btn_izq     = 1'b0;
    bus.btn_der     = 1'b0;
    bus.btn_ok      = 1'b0;
    bus.nuevo_juego = 1'b0;
    m_cursor = 4'd4; m_turno = 1'b0; m_x = 9'd0; m_o = 9'd0; m_jugada = 6'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_values("rst");

    // Held der acts once
    bus.btn_der = 1'b1;
    repeat (5) tick();
    bus.btn_der = 1'b0;
    tick();
    check("held_der_cursor", {12'd0, bus.cursor}, 16'd5);
    check("held_der_jugada", {10'd0, bus.jugada}, 16'd0);
    check("held_der_lleno",  {15'd0, bus.lleno}, 16'd0);
    m_cursor = 4'd5;

    // Cursor wrap both ways, simultaneous press
    repeat (3) press_der();
    check("cursor_at_8", {12'd0, bus.cursor}, 16'd8);
    press_der();
    check("wrap_8_to_0", {12'd0, bus.cursor}, 16'd0);
    press_izq();
    check("wrap_0_to_8", {12'd0, bus.cursor}, 16'd8);
    bus.btn_izq = 1'b1; bus.btn_der = 1'b1; tick();
    bus.btn_izq = 1'b0; bus.btn_der = 1'b0; tick();
    check("izq_der_together", {12'd0, bus.cursor}, 16'd8);
    m_cursor = 4'd8;

    // First X move on centre cell, check EMITE-cycle visibility
    repeat (4) begin press_izq(); model_izq(); end
    check("back_to_4", {12'd0, bus.cursor}, 16'd4);
    exp_q.push_back({1'b0, 6'b01_0100});
    bus.btn_ok = 1'b1; tick();
    check("emite_valida", {15'd0, bus.jugada_valida}, 16'd1);
    check("emite_jugada", {10'd0, bus.jugada}, 16'b01_0100);
    check("emite_tab_x",  {7'd0, bus.tablero_x}, 16'h010);
    check("emite_turno",  {15'd0, bus.turno}, 16'd0);
    bus.btn_ok = 1'b0; tick();
    check("after_emite_valida", {15'd0, bus.jugada_valida}, 16'd0);
    m_x = 9'h010; m_turno = 1'b1; m_jugada = 6'b01_0100;
    check_state("move1");

    // Occupied cell rejected on O's turn
    exp_q.push_back({1'b1, m_jugada});
    bus.btn_ok = 1'b1; tick();
    check("ocupada_strobe", {15'd0, bus.ocupada}, 16'd1);
    bus.btn_ok = 1'b0; tick();
    check("ocupada_one_cycle", {15'd0, bus.ocupada}, 16'd0);
    check_state("occupied");

    // Fill remaining cells: O 0, X 1, O 2, X 3, O 5, X 6, O 7, X 8
    goto(4'd0); place();
    goto(4'd1); place();
    goto(4'd2); place();
    goto(4'd3); place();
    goto(4'd5); place();
    goto(4'd6); place();
    goto(4'd7); place();
    goto(4'd8); place();
    check_state("full");
    check("full_tab_x_const", {7'd0, bus.tablero_x}, 16'h15A);
    check("full_tab_o_const", {7'd0, bus.tablero_o}, 16'h0A5);
    check("full_lleno",  {15'd0, bus.lleno}, 16'd1);
    check("full_estado", {14'd0, bus.estado}, 16'd2);
    check("full_jugada_hold", {10'd0, bus.jugada}, 16'b01_1000);

    // Buttons ignored in FIN
    bus.btn_ok = 1'b1; tick(); bus.btn_ok = 1'b0; tick();
    press_der();
    press_izq();
    check_state("fin_ignore");
    check("fin_lleno_hold", {15'd0, bus.lleno}, 16'd1);
    check("fin_jugada_hold", {10'd0, bus.jugada}, 16'b01_1000);

    // nuevo_juego leaves FIN
    bus.nuevo_juego = 1'b1; tick();
    bus.nuevo_juego = 1'b0; tick();
    check_reset_values("nuevo");
    m_cursor = 4'd4; m_turno = 1'b0; m_x = 9'd0; m_o = 9'd0;

    // nuevo_juego with ok during EMITE
    exp_q.push_back({1'b0, 6'b01_0100});
    bus.btn_ok = 1'b1; tick();
    check("emite2_valida", {15'd0, bus.jugada_valida}, 16'd1);
    bus.nuevo_juego = 1'b1; tick();
    check_reset_values("nuevo_emite");
    bus.nuevo_juego = 1'b0;
    bus.btn_ok = 1'b0;
    repeat (3) tick();
    check_reset_values("settled");

    check("queue_drained", exp_q.size(), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
